// File: rtl/rgb_cmp_selftest.sv
// rgb_cmp_selftest: on-chip sweep of every operand pair through a 2-input
// magnitude comparator with one-hot red(>)/green(==)/blue(<) outputs.
// Ports: clk, rst_n (async, active low), start (level),
//   a_out/b_out (operands to comparator), red_in/green_in/blue_in
//   (comparator response), busy, done, pass, err_count,
//   first_fail_valid, first_fail_idx ({a,b} of first mismatch).
// Optional: define RGB_SELFTEST_STOP_ON_FAIL_EN to end the sweep at the
//   first mismatch, leaving the failing vector on a_out/b_out.
module rgb_cmp_selftest #(
   parameter int WIDTH         = 2,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic [WIDTH-1:0]     a_out,
   output logic [WIDTH-1:0]     b_out,
   input  logic                 red_in,
   input  logic                 green_in,
   input  logic                 blue_in,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2*WIDTH:0]     err_count,
   output logic                 first_fail_valid,
   output logic [2*WIDTH-1:0]   first_fail_idx
);

   localparam int IW = 2 * WIDTH;

   // Last settle count; unused when SETTLE_CYCLES is 0.
   localparam logic [3:0] SC_LAST =
      4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
   localparam logic [IW-1:0] IDX_ONE = IW'(1);
   localparam logic [IW:0]   ERR_ONE = (IW+1)'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [IW-1:0]     r_idx;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [3:0]        r_cnt;
   logic [IW:0]       r_err;
   logic              r_ffv;
   logic [IW-1:0]     r_ffi;

   logic [2:0]        w_exp;
   logic              w_mismatch;
   logic              w_last;
   logic              w_launch;
   logic              w_advance;

   // Expected response follows the operands actually presented, so any
   // response that is not exactly this one-hot code is a mismatch.
   assign w_exp      = {r_a > r_b, r_a == r_b, r_a < r_b};
   assign w_mismatch = ({red_in, green_in, blue_in} != w_exp);
   assign w_last     = &r_idx;
   assign w_launch   = start &&
                       (r_state == S_IDLE || r_state == S_DONE);
   assign w_advance  = (r_state == S_SAMPLE) && (w_next == S_DRIVE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (start) w_next = S_DRIVE;
         end
         S_DRIVE: begin
            w_next = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
         end
         S_SETTLE: begin
            if (r_cnt == SC_LAST) w_next = S_SAMPLE;
         end
         S_SAMPLE: begin
`ifdef RGB_SELFTEST_STOP_ON_FAIL_EN
            if (w_mismatch || w_last) w_next = S_DONE;
            else                      w_next = S_DRIVE;
`else
            if (w_last) w_next = S_DONE;
            else        w_next = S_DRIVE;
`endif
         end
         S_DONE: begin
            if (start) w_next = S_DRIVE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_cnt <= '0;
         r_err <= '0;
         r_ffv <= 1'b0;
         r_ffi <= '0;
      end else begin
         if (w_launch) begin
            r_idx <= '0;
            r_err <= '0;
            r_ffv <= 1'b0;
            r_ffi <= '0;
         end
         if (r_state == S_DRIVE) begin
            r_a   <= r_idx[IW-1:WIDTH];
            r_b   <= r_idx[WIDTH-1:0];
            r_cnt <= '0;
         end
         if (r_state == S_SETTLE) begin
            r_cnt <= r_cnt + 4'd1;
         end
         if (r_state == S_SAMPLE && w_mismatch) begin
            r_err <= r_err + ERR_ONE;
            if (!r_ffv) begin
               r_ffv <= 1'b1;
               r_ffi <= r_idx;
            end
         end
         if (w_advance) begin
            r_idx <= r_idx + IDX_ONE;
         end
      end
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      pass = 1'b0;
      unique case (r_state)
         S_DRIVE, S_SETTLE, S_SAMPLE: begin
            busy = 1'b1;
         end
         S_DONE: begin
            done = 1'b1;
            pass = (r_err == '0);
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign a_out            = r_a;
   assign b_out            = r_b;
   assign err_count        = r_err;
   assign first_fail_valid = r_ffv;
   assign first_fail_idx   = r_ffi;

endmodule

// File: tb/tb_rgb_cmp_selftest.sv
// tb_rgb_cmp_selftest: drives three self-test instances (settle 2/0/1)
// against ideal, faulty, randomly corrupted and registered comparators.
module tb_rgb_cmp_selftest;

   localparam int W  = 2;
   localparam int NV = 1 << (2 * W);
   localparam int NB = 1 << W;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int mode = 0;
   int sel = 0;
   logic [2:0] tab [NV];

   logic [W-1:0] a0, b0, az, bz, ao, bo;
   logic r0, g0, l0, rz, gz, lz, ro, go, lo;
   logic busy0, done0, pass0, busyz, donez, passz, busyo, doneo, passo;
   logic [2*W:0] err0, errz, erro;
   logic ffv0, ffvz, ffvo;
   logic [2*W-1:0] ffi0, ffiz, ffio;

   rgb_cmp_selftest #(.WIDTH(W), .SETTLE_CYCLES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a_out(a0), .b_out(b0),
      .red_in(r0), .green_in(g0), .blue_in(l0),
      .busy(busy0), .done(done0), .pass(pass0),
      .err_count(err0), .first_fail_valid(ffv0),
      .first_fail_idx(ffi0));

   rgb_cmp_selftest #(.WIDTH(W), .SETTLE_CYCLES(0)) u_s0 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a_out(az), .b_out(bz),
      .red_in(rz), .green_in(gz), .blue_in(lz),
      .busy(busyz), .done(donez), .pass(passz),
      .err_count(errz), .first_fail_valid(ffvz),
      .first_fail_idx(ffiz));

   rgb_cmp_selftest #(.WIDTH(W), .SETTLE_CYCLES(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a_out(ao), .b_out(bo),
      .red_in(ro), .green_in(go), .blue_in(lo),
      .busy(busyo), .done(doneo), .pass(passo),
      .err_count(erro), .first_fail_valid(ffvo),
      .first_fail_idx(ffio));

   function automatic logic [2:0] ideal(input int a, input int b);
      return {a > b, a == b, a < b};
   endfunction

   // mode 0 ideal, 1 green stuck 0, 2 red/blue swapped,
   // 3 blue stuck 1, 4 ideal xor random corruption table
   function automatic logic [2:0] faulty(input int a, input int b,
                                          input int m, input logic [2:0] t);
      logic [2:0] i;
      i = ideal(a, b);
      case (m)
         1: return i & 3'b101;
         2: return {i[0], i[1], i[2]};
         3: return i | 3'b001;
         4: return i ^ t;
         default: return i;
      endcase
   endfunction

   always_comb {r0, g0, l0} = faulty(int'(a0), int'(b0), mode, tab[{a0, b0}]);

   // Comparators with a one-cycle output register.
   always @(posedge clk) begin
      {rz, gz, lz} <= ideal(int'(az), int'(bz));
      {ro, go, lo} <= ideal(int'(ao), int'(bo));
   end

   logic s_busy, s_done, s_pass, s_ffv;
   logic [2*W:0] s_err;
   logic [2*W-1:0] s_ffi;
   logic [W-1:0] s_a, s_b;
   always_comb begin
      case (sel)
         1: {s_busy, s_done, s_pass, s_ffv, s_err, s_ffi, s_a, s_b} =
               {busyz, donez, passz, ffvz, errz, ffiz, az, bz};
         2: {s_busy, s_done, s_pass, s_ffv, s_err, s_ffi, s_a, s_b} =
               {busyo, doneo, passo, ffvo, erro, ffio, ao, bo};
         default: {s_busy, s_done, s_pass, s_ffv, s_err, s_ffi, s_a, s_b} =
               {busy0, done0, pass0, ffv0, err0, ffi0, a0, b0};
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_a"}, 32'(a0), 0);
      check({tag, "_b"}, 32'(b0), 0);
      check({tag, "_busy"}, 32'(busy0), 0);
      check({tag, "_done"}, 32'(done0), 0);
      check({tag, "_pass"}, 32'(pass0), 0);
      check({tag, "_err"}, 32'(err0), 0);
      check({tag, "_ffv"}, 32'(ffv0), 0);
      check({tag, "_ffi"}, 32'(ffi0), 0);
   endtask

   // Which vectors the default instance's comparator gets wrong.
   function automatic logic [NV-1:0] mm_default();
      logic [NV-1:0] m;
      for (int v = 0; v < NV; v++)
         m[v] = faulty(v / NB, v % NB, mode, tab[v]) !== ideal(v / NB, v % NB);
      return m;
   endfunction

   // Registered comparator, no settle: vector v sees the response to v-1
   // (vector 0 sees the reset operands 0/0).
   function automatic logic [NV-1:0] mm_reg();
      logic [NV-1:0] m;
      int p;
      for (int v = 0; v < NV; v++) begin
         p = (v == 0) ? 0 : v - 1;
         m[v] = ideal(p / NB, p % NB) !== ideal(v / NB, v % NB);
      end
      return m;
   endfunction

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy0 | busyz | busyo) && n < 400) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_sweep(input int sel_i, input int per,
                            input logic [NV-1:0] mm, input string tag);
      int cnt, first, e_err, last, cyc, n;
      cnt = 0;
      first = 0;
      for (int v = NV - 1; v >= 0; v--)
         if (mm[v]) begin
            cnt++;
            first = v;
         end
`ifdef RGB_SELFTEST_STOP_ON_FAIL_EN
      e_err = (cnt > 0) ? 1 : 0;
      last  = (cnt > 0) ? first : NV - 1;
      cyc   = (cnt > 0) ? (first + 1) * per : NV * per;
`else
      e_err = cnt;
      last  = NV - 1;
      cyc   = NV * per;
`endif
      sel = sel_i;
      wait_idle();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!s_done && n < 2 * NV * per + 20) begin
         if (s_busy) n++;
         @(negedge clk);
      end
      check({tag, "_done"}, 32'(s_done), 1);
      check({tag, "_busy"}, 32'(s_busy), 0);
      check({tag, "_cycles"}, 32'(n), 32'(cyc));
      check({tag, "_err"}, 32'(s_err), 32'(e_err));
      check({tag, "_pass"}, 32'(s_pass), 32'(cnt == 0));
      check({tag, "_ffv"}, 32'(s_ffv), 32'(cnt > 0));
      check({tag, "_ffi"}, 32'(s_ffi), 32'((cnt > 0) ? first : 0));
      check({tag, "_a"}, 32'(s_a), 32'(last / NB));
      check({tag, "_b"}, 32'(s_b), 32'(last % NB));
   endtask

   initial begin
      int n;
      for (int v = 0; v < NV; v++) tab[v] = 3'b000;
      #2;
      check_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      mode = 0; run_sweep(0, 4, mm_default(), "ideal");
      mode = 1; run_sweep(0, 4, mm_default(), "green0");
      mode = 2; run_sweep(0, 4, mm_default(), "swap");
      mode = 3; run_sweep(0, 4, mm_default(), "blue1");

      mode = 4;
      for (int k = 0; k < 6; k++) begin
         for (int v = 0; v < NV; v++)
            tab[v] = ($urandom_range(0, 3) == 0) ?
                     3'($urandom_range(1, 7)) : 3'b000;
         run_sweep(0, 4, mm_default(), $sformatf("rand%0d", k));
      end

      // start held high: full sweep, one DONE cycle, then re-sweep
      mode = 0;
      sel = 0;
      wait_idle();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      n = 0;
      while (!done0 && n < 300) begin
         if (busy0) n++;
         @(negedge clk);
      end
      check("hold_cycles", 32'(n), 32'(NV * 4));
      check("hold_done", 32'(done0), 1);
      check("hold_pass", 32'(pass0), 1);
      @(negedge clk);
      check("hold_rebusy", 32'(busy0), 1);
      check("hold_redone", 32'(done0), 0);
      start = 1'b0;

      // reset in the middle of a sweep, at vector 7 (a=1, b=3)
`ifdef RGB_SELFTEST_STOP_ON_FAIL_EN
      mode = 0;
`else
      mode = 2;
`endif
      wait_idle();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(a0 == 2'd1 && b0 == 2'd3) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("mid_reach", 32'(n < 200), 1);
      #1 rst_n = 1'b0;
      #1;
      check_zero("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      mode = 0;
      run_sweep(0, 4, mm_default(), "post_rst");

      // registered comparator with no settle, then with one settle cycle
      wait_idle();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_sweep(1, 2, mm_reg(), "set0");
      run_sweep(2, 3, '0, "set1");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rgb_cmp_selftest.md
Name: rgb_cmp_selftest

Overview:
Sequential self-test initiator for the 2-bit magnitude comparator with RGB outputs. It drives every operand pair (a, b) in turn, waits for the outputs to settle, then checks red/green/blue against the expected result. It reports pass/fail, an error count and the first failing vector. It replaces the hand-written stimulus sweep with synthesizable on-chip checking.

Parameters:
WIDTH, 2, operand width; the sweep covers 2^(2*WIDTH) vectors; legal range 1..4
SETTLE_CYCLES, 2, wait cycles between driving a vector and sampling the response; legal range 0..15

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  level; begins a sweep when sampled high in IDLE or DONE
a_out  out  WIDTH  operand a to the comparator
b_out  out  WIDTH  operand b to the comparator
red_in  in  1  comparator output; expected 1 iff a > b
green_in  in  1  comparator output; expected 1 iff a == b
blue_in  in  1  comparator output; expected 1 iff a < b
busy  out  1  high while a sweep is in progress
done  out  1  high from sweep end until the next start or reset
pass  out  1  valid while done=1; 1 iff err_count == 0
err_count  out  2*WIDTH+1  number of mismatching vectors
first_fail_valid  out  1  set at the first mismatch of a sweep
first_fail_idx  out  2*WIDTH  vector index {a,b} of the first mismatch

Behaviour:
- Reset (async, rst_n=0): state=IDLE; a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_idx=0; vector index=0, settle counter=0.
- Vector index idx is 2*WIDTH bits wide. a_out=idx[2W-1:W], b_out=idx[W-1:0]. Order: a-major, b-minor, ascending from 0.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
  - IDLE: start=1 -> DRIVE. idx, err_count, first_fail_* and done are all cleared on that edge.
  - DRIVE, 1 cycle: a_out/b_out are registered from idx. busy=1. Next state is SETTLE, or SAMPLE if SETTLE_CYCLES=0.
  - SETTLE: counts SETTLE_CYCLES cycles, then goes to SAMPLE.
  - SAMPLE, 1 cycle: compares {red_in,green_in,blue_in} with the expected one-hot value.
    - Any difference counts as a mismatch, including 000, multi-hot or the wrong colour.
    - On mismatch: err_count increments. If first_fail_valid=0, first_fail_idx<=idx and first_fail_valid<=1.
    - If idx is all-ones -> DONE. Otherwise idx increments and the FSM returns to DRIVE.
  - DONE: busy=0, done=1, pass=(err_count==0). a_out/b_out hold the last vector. start=1 -> restart exactly as from IDLE.
- Per-vector period is SETTLE_CYCLES+2 cycles. A full sweep at the defaults takes 16*4=64 cycles from the first DRIVE to DONE.
- start is ignored while busy=1. If start is held high, the block re-sweeps on the cycle after each DONE.
- err_count cannot overflow, because its maximum value 2^(2W) fits in its width.
- Reset asserted mid-sweep aborts immediately to the reset values. No partial result is retained.
- red_in/green_in/blue_in share clk's domain. No synchronizer is present.

Optional Feature:
RGB_SELFTEST_STOP_ON_FAIL_EN
- Defined: the first mismatch in SAMPLE goes straight to DONE with err_count=1 and pass=0. a_out/b_out hold the failing vector for inspection.
- Undefined: the full sweep always completes and err_count holds the total number of mismatches.

Test Plan:
- Ideal comparator model, defaults; reset, start pulse -> busy=1 for 64 cycles; done=1, pass=1, err_count=0, first_fail_valid=0; a_out/b_out end at 3/3.
- Model with green stuck at 0 -> done; err_count=4; first_fail_idx=0 (a=0,b=0); pass=0.
- Model with red and blue swapped -> err_count=12; first_fail_idx=1 (a=0,b=1).
- rst_n pulsed low at vector idx=7 -> all outputs return to 0 immediately; a new start gives a full clean 64-cycle sweep with err_count=0.
- SETTLE_CYCLES=0, comparator modelled with a 1-cycle output register -> mismatches reported; SETTLE_CYCLES=1 with the same model -> pass=1.
- RGB_SELFTEST_STOP_ON_FAIL_EN defined, blue stuck at 1 -> DONE after vector 0; err_count=1; a_out=0, b_out=0.
